// File: rtl/stream_demux_1ton.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_1ton
// Description : Registered 1-to-N valid/ready stream demultiplexer with
//               packet-level destination locking and a dropped-packet counter.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux_1ton #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [N_OUT-1:0]  out_valid,
    input  logic [N_OUT-1:0]  out_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  drop_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [SEL_W:0]   c_n_out   = (SEL_W+1)'(N_OUT);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SEL_W-1:0]    r_dest;
    logic                r_drop;
    logic [N_OUT-1:0]    r_out_valid;
    logic [DATA_W-1:0]   r_data;
    logic                r_last;
    logic [CNT_W-1:0]    r_drop_cnt;

    logic [SEL_W-1:0]    w_dest;
    logic                w_invalid;
    logic [N_OUT-1:0]    w_dest_onehot;
    logic                w_hold_valid;
    logic                w_sel_ready;
    logic                w_in_ready;
    logic                w_fire;

    // Destination comes from in_sel only on the first beat; later beats reuse the lock.
    always_comb begin
        w_dest    = in_sel;
        w_invalid = ({1'b0, in_sel} >= c_n_out);
        if (r_state == ST_LOCKED) begin
            w_dest    = r_dest;
            w_invalid = r_drop;
        end
    end

    for (genvar i = 0; i < N_OUT; i++) begin : g_onehot
        assign w_dest_onehot[i] = (w_dest == SEL_W'(i));
    end

    // r_out_valid is one-hot, so masking with out_ready picks the held channel's ready.
    assign w_hold_valid = |r_out_valid;
    assign w_sel_ready  = |(r_out_valid & out_ready);
    assign w_in_ready   = !w_hold_valid | w_sel_ready;
    assign w_fire       = in_valid & w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_fire && !in_last) w_state_nxt = ST_LOCKED;
            ST_LOCKED: if (w_fire && in_last)  w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dest <= '0;
            r_drop <= 1'b0;
        end else if (r_state == ST_IDLE && w_fire && !in_last) begin
            r_dest <= in_sel;
            r_drop <= w_invalid;
        end
    end

    // A push replaces the held beat in the same cycle it is popped, so no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= '0;
            r_data      <= '0;
            r_last      <= 1'b0;
        end else if (w_fire && !w_invalid) begin
            r_out_valid <= w_dest_onehot;
            r_data      <= in_data;
            r_last      <= in_last;
        end else if (w_sel_ready) begin
            r_out_valid <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_fire && in_last && w_invalid && (r_drop_cnt != c_cnt_max)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_data;
    assign out_last  = r_last;
    assign out_valid = r_out_valid;
    assign busy      = (r_state == ST_LOCKED);
    assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_stream_demux_1ton.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_demux_1ton
// Description : Self-checking bench: behavioural model plus per-channel
//               scoreboard for a 4-output instance, directed drop checks on a
//               3-output instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_demux_1ton;

    localparam int N = 4;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] in_data;
    logic [1:0] in_sel;
    logic       in_last, in_valid, in_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic [3:0] out_valid, out_ready;
    logic       busy;
    logic [7:0] drop_cnt;

    logic [7:0] d3_in_data;
    logic [1:0] d3_in_sel;
    logic       d3_in_last, d3_in_valid, d3_in_ready;
    logic [7:0] d3_out_data;
    logic       d3_out_last;
    logic [2:0] d3_out_valid, d3_out_ready;
    logic       d3_busy;
    logic [7:0] d3_drop_cnt;

    stream_demux_1ton #(.DATA_W(8), .N_OUT(4), .SEL_W(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
        .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .drop_cnt(drop_cnt)
    );

    stream_demux_1ton #(.DATA_W(8), .N_OUT(3), .SEL_W(2), .CNT_W(8)) dut3 (
        .clk(clk), .rst(rst), .in_data(d3_in_data), .in_sel(d3_in_sel),
        .in_last(d3_in_last), .in_valid(d3_in_valid), .in_ready(d3_in_ready),
        .out_data(d3_out_data), .out_last(d3_out_last), .out_valid(d3_out_valid),
        .out_ready(d3_out_ready), .busy(d3_busy), .drop_cnt(d3_drop_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one output slot, packet lock, drop count, per-channel queues.
    logic       m_valid  = 1'b0;
    int         m_dest   = 0;
    logic [7:0] m_data   = 8'h00;
    logic       m_last   = 1'b0;
    logic       m_locked = 1'b0;
    int         m_ldest  = 0;
    int         m_drop   = 0;
    int         cyc      = 0;
    int         m_d;
    logic       m_pop, m_rdy;
    logic [8:0] expq [N][$];
    logic       chk_en = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_valid  = 1'b0;
            m_locked = 1'b0;
            m_drop   = 0;
            for (int i = 0; i < N; i++) expq[i].delete();
        end else begin
            m_pop = m_valid && out_ready[m_dest];
            m_rdy = !m_valid || out_ready[m_dest];
            if (in_valid && m_rdy) begin
                m_d = m_locked ? m_ldest : int'(in_sel);
                if (!m_locked && !in_last) begin
                    m_locked = 1'b1;
                    m_ldest  = int'(in_sel);
                end else if (m_locked && in_last) begin
                    m_locked = 1'b0;
                end
                if (m_d < N) begin
                    m_valid = 1'b1;
                    m_dest  = m_d;
                    m_data  = in_data;
                    m_last  = in_last;
                    expq[m_d].push_back({in_last, in_data});
                end else begin
                    if (m_pop) m_valid = 1'b0;
                    if (in_last && m_drop < 255) m_drop++;
                end
            end else if (m_pop) begin
                m_valid = 1'b0;
            end
        end
    end

    logic [8:0] sb_e;
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("out_valid", out_valid, m_valid ? (32'd1 << m_dest) : 32'd0);
            chk("in_ready", in_ready, (!m_valid || out_ready[m_dest]) ? 1 : 0);
            chk("busy", busy, m_locked);
            chk("drop_cnt", drop_cnt, m_drop);
            if (m_valid) begin
                chk("out_data", out_data, m_data);
                chk("out_last", out_last, m_last);
            end
            for (int i = 0; i < N; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    if (expq[i].size() == 0) begin
                        chk("sb_unexpected_beat", 1, 0);
                    end else begin
                        sb_e = expq[i].pop_front();
                        chk("sb_beat", {out_last, out_data}, sb_e);
                    end
                end
            end
        end
    end

    // Called at posedge+2; returns at posedge+2 after the accepting edge.
    task automatic send(input logic [7:0] d, input logic [1:0] s, input logic l);
        int   t;
        logic acc;
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
        in_last  = l;
        t = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #2;
            t++;
        end while (!acc && t < 200);
        if (!acc) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int   c0, beats, len;
    logic rand_done;
    logic [1:0] s;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_sel = '0; in_last = 1'b0;
        out_ready = 4'hF;
        d3_in_valid = 1'b0; d3_in_data = '0; d3_in_sel = '0; d3_in_last = 1'b0;
        d3_out_ready = 3'b111;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_d3_drop_cnt", d3_drop_cnt, 0);
        chk_en = 1'b1;

        // Single-beat packets to every channel.
        for (int k = 0; k < 4; k++) begin
            send(8'hA5, 2'(k), 1'b1);
            chk("t1_onehot", out_valid, 32'd1 << k);
            chk("t1_data", out_data, 8'hA5);
            chk("t1_last", out_last, 1);
        end

        // Lock keeps channel 2 although in_sel moves to 0.
        send(8'h11, 2'd2, 1'b0);
        chk("t2_busy_b1", busy, 1);
        chk("t2_ch_b1", out_valid, 4'b0100);
        send(8'h22, 2'd0, 1'b0);
        chk("t2_ch_b2", out_valid, 4'b0100);
        chk("t2_data_b2", out_data, 8'h22);
        send(8'h33, 2'd0, 1'b1);
        chk("t2_ch_b3", out_valid, 4'b0100);
        chk("t2_data_b3", out_data, 8'h33);
        chk("t2_busy_end", busy, 0);
        @(posedge clk); #2;

        // Back-pressure on channel 1 for 4 cycles.
        out_ready = 4'b1101;
        fork
            begin
                send(8'h41, 2'd1, 1'b0);
                send(8'h42, 2'd1, 1'b1);
            end
            begin
                repeat (4) begin
                    @(posedge clk); #1;
                    chk("t3_hold_data", out_data, 8'h41);
                    chk("t3_in_ready", in_ready, 0);
                end
                #1 out_ready = 4'hF;
            end
        join
        chk("t3_second", out_data, 8'h42);
        chk("t3_ch", out_valid, 4'b0010);

        // Reset in the middle of a packet.
        send(8'hC0, 2'd3, 1'b0);
        send(8'hC1, 2'd3, 1'b0);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        chk("t5_out_valid", out_valid, 0);
        chk("t5_busy", busy, 0);
        send(8'h5A, 2'd1, 1'b1);
        chk("t5_route", out_valid, 4'b0010);
        chk("t5_data", out_data, 8'h5A);

        // Continuous alternating stream: one beat per cycle.
        c0 = cyc;
        beats = 0;
        for (int p = 0; p < 20; p++) begin
            len = 1 + p % 3;
            for (int b = 0; b < len; b++) begin
                send(8'(p * 16 + b), (p % 2) ? 2'd3 : 2'd0, b == len - 1);
                beats++;
            end
        end
        chk("t6_no_bubbles", cyc - c0, beats);

        // Randomised traffic and back-pressure.
        rand_done = 1'b0;
        fork
            begin
                for (int p = 0; p < 300; p++) begin
                    len = $urandom_range(1, 4);
                    s   = 2'($urandom_range(0, 3));
                    for (int b = 0; b < len; b++) begin
                        send(8'($urandom), (b == 0) ? s : 2'($urandom_range(0, 3)), b == len - 1);
                        if ($urandom_range(0, 3) == 0) begin
                            @(posedge clk); #2;
                        end
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #2;
                    out_ready = 4'($urandom);
                end
            end
        join
        out_ready = 4'hF;
        repeat (3) begin @(posedge clk); #2; end
        for (int i = 0; i < N; i++) chk("sb_drain", expq[i].size(), 0);

        // Drops on the 3-output instance, saturating at 255.
        d3_in_valid = 1'b1; d3_in_sel = 2'd3; d3_in_last = 1'b1; d3_in_data = 8'h77;
        for (int k = 0; k < 260; k++) begin
            @(posedge clk); #1;
            chk("t4_in_ready", d3_in_ready, 1);
            chk("t4_no_valid", d3_out_valid, 0);
            if (k == 0)   chk("t4_first_drop", d3_drop_cnt, 1);
            if (k == 254) chk("t4_reach_max", d3_drop_cnt, 255);
            #1;
        end
        chk("t4_saturated", d3_drop_cnt, 255);
        d3_in_sel = 2'd1; d3_in_data = 8'h5C;
        @(posedge clk); #1;
        d3_in_valid = 1'b0;
        chk("t4_valid_route", d3_out_valid, 3'b010);
        chk("t4_valid_data", d3_out_data, 8'h5C);
        chk("t4_cnt_hold", d3_drop_cnt, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
